// File: rtl/edge_detect_multi.sv
// edge_detect_multi: per-channel programmable edge detector with tick pulse,
// sticky pending flag and saturating event counter.
// Optional build macro: EDGE_DETECT_MULTI_SYNC_EN inserts a 2-flop
// synchroniser on every level input. It raises the event latency to 3 cycles
// and the post-reset priming window to 3 edges.
module edge_detect_multi #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_CH-1:0]         i_level,
  input  logic [2*N_CH-1:0]       i_mode,
  input  logic [N_CH-1:0]         i_clr,
  output logic [N_CH-1:0]         o_tick,
  output logic [N_CH-1:0]         o_pending,
  output logic [N_CH*CNT_W-1:0]   o_count,
  output logic                    o_any
);

`ifdef EDGE_DETECT_MULTI_SYNC_EN
  // Cover both synchroniser stages plus the r_prev load.
  localparam logic [1:0] PRIME_EDGES = 2'd3;
`else
  localparam logic [1:0] PRIME_EDGES = 2'd1;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [N_CH-1:0]       level_s;
  logic [N_CH-1:0]       rise_s;
  logic [N_CH-1:0]       fall_s;
  logic [N_CH-1:0]       qual_s;
  logic                  priming_s;

  logic [N_CH-1:0]       prev_q;
  logic [N_CH-1:0]       tick_q;
  logic [N_CH-1:0]       pending_q;
  logic [N_CH-1:0]       pending_d;
  logic [N_CH*CNT_W-1:0] count_q;
  logic [N_CH*CNT_W-1:0] count_d;
  logic                  any_q;
  logic [1:0]            prime_q;
  logic [1:0]            prime_d;

`ifdef EDGE_DETECT_MULTI_SYNC_EN
  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;

  // Two-flop synchroniser for the asynchronous level inputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= {N_CH{1'b0}};
      sync2_q <= {N_CH{1'b0}};
    end else begin
      sync1_q <= i_level;
      sync2_q <= sync1_q;
    end
  end

  assign level_s = sync2_q;
`else
  assign level_s = i_level;
`endif

  // Raw edges against the previously sampled level; mode qualification below.
  assign rise_s = ~prev_q & level_s;
  assign fall_s = prev_q & ~level_s;

  // Event qualification, priming countdown and pending/counter next state.
  always_comb begin
    prime_d   = prime_q;
    pending_d = pending_q;
    count_d   = count_q;
    qual_s    = {N_CH{1'b0}};
    priming_s = (prime_q != 2'd0);

    if (priming_s) begin
      prime_d = prime_q - 2'd1;
    end else begin
      prime_d = prime_q;
    end

    for (int n = 0; n < N_CH; n++) begin
      qual_s[n] = ~priming_s &
                  ((rise_s[n] & i_mode[2*n]) | (fall_s[n] & i_mode[2*n+1]));

      case ({qual_s[n], i_clr[n]})
        2'b11: begin
          // A clear on the same edge as an event loses to the event.
          pending_d[n]                = 1'b1;
          count_d[n*CNT_W +: CNT_W]   = CNT_ONE;
        end
        2'b10: begin
          pending_d[n] = 1'b1;
          if (count_q[n*CNT_W +: CNT_W] != CNT_MAX) begin
            count_d[n*CNT_W +: CNT_W] = count_q[n*CNT_W +: CNT_W] + CNT_ONE;
          end else begin
            count_d[n*CNT_W +: CNT_W] = count_q[n*CNT_W +: CNT_W];
          end
        end
        2'b01: begin
          pending_d[n]              = 1'b0;
          count_d[n*CNT_W +: CNT_W] = {CNT_W{1'b0}};
        end
        2'b00: begin
          pending_d[n]              = pending_q[n];
          count_d[n*CNT_W +: CNT_W] = count_q[n*CNT_W +: CNT_W];
        end
        default: begin
          pending_d[n]              = pending_q[n];
          count_d[n*CNT_W +: CNT_W] = count_q[n*CNT_W +: CNT_W];
        end
      endcase
    end
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q    <= {N_CH{1'b0}};
      tick_q    <= {N_CH{1'b0}};
      pending_q <= {N_CH{1'b0}};
      count_q   <= {(N_CH*CNT_W){1'b0}};
      any_q     <= 1'b0;
      prime_q   <= PRIME_EDGES;
    end else begin
      // r_prev tracks in every mode so enabling a mode never fakes an edge.
      prev_q    <= level_s;
      tick_q    <= qual_s;
      pending_q <= pending_d;
      count_q   <= count_d;
      // o_any trails o_pending by one cycle.
      any_q     <= |pending_q;
      prime_q   <= prime_d;
    end
  end

  assign o_tick    = tick_q;
  assign o_pending = pending_q;
  assign o_count   = count_q;
  assign o_any     = any_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi: a default instance (4 ch, 8-bit counts)
// and a narrow-counter instance (4 ch, 2-bit counts) share the same stimulus.
module tb_edge_detect_multi;

`ifdef EDGE_DETECT_MULTI_SYNC_EN
  localparam int XL = 2;
`else
  localparam int XL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  level;
  logic [7:0]  mode;
  logic [3:0]  clr;

  logic [3:0]  tick_a;
  logic [3:0]  pend_a;
  logic [31:0] cnt_a;
  logic        any_a;
  logic [3:0]  tick_b;
  logic [3:0]  pend_b;
  logic [7:0]  cnt_b;
  logic        any_b;

  int n_tests = 0;
  int n_fail  = 0;
  int ticks1;
  int ticks2;
  int exp_cnt;

  always #5 clk = ~clk;

  edge_detect_multi #(.N_CH(4), .CNT_W(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_level(level), .i_mode(mode), .i_clr(clr),
    .o_tick(tick_a), .o_pending(pend_a), .o_count(cnt_a), .o_any(any_a)
  );

  edge_detect_multi #(.N_CH(4), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_level(level), .i_mode(mode), .i_clr(clr),
    .o_tick(tick_b), .o_pending(pend_b), .o_count(cnt_b), .o_any(any_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, 32'(tick_a), 32'd0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    level = 4'hF;
    mode  = 8'h55;
    clr   = 4'h0;
    repeat (3) step();
    chk("rst_tick",  32'(tick_a), 32'd0);
    chk("rst_pend",  32'(pend_a), 32'd0);
    chk("rst_count", cnt_a,       32'd0);
    chk("rst_any",   32'(any_a),  32'd0);
    chk("rst_cnt_b", 32'(cnt_b),  32'd0);
    chk("rst_any_b", 32'(any_b),  32'd0);

    // Level high through reset release: priming must hide it.
    rst = 1'b0;
    quiet("prime_hi_tick", 4 + XL);
    chk("prime_hi_pend", 32'(pend_a), 32'd0);

    // Mode 00 never qualifies.
    mode  = 8'h00;
    level = 4'h0;
    quiet("mode00_fall", 2 + XL);
    level = 4'hF;
    quiet("mode00_rise", 2 + XL);
    chk("mode00_pend", 32'(pend_a), 32'd0);

    // Enabling rising mode while level is high creates no event.
    mode = 8'h55;
    quiet("enable_tick", 3 + XL);
    chk("enable_pend", 32'(pend_a), 32'd0);
    level = 4'h0;
    quiet("fall_in_rise_mode", 2 + XL);
    chk("fall_in_rise_pend", 32'(pend_a), 32'd0);

    // Single rising event on ch0.
    level = 4'b0001;
    repeat (XL) step();
    step();
    chk("rise0_tick",  32'(tick_a),     32'h1);
    chk("rise0_pend",  32'(pend_a),     32'h1);
    chk("rise0_count", 32'(cnt_a[7:0]), 32'd1);
    chk("rise0_any_lag", 32'(any_a),    32'd0);
    step();
    chk("rise0_tick_off", 32'(tick_a),  32'h0);
    chk("rise0_any",      32'(any_a),   32'd1);
    chk("rise0_count_hold", cnt_a,      32'h0000_0001);

    // Clear coincident with an event: the event wins.
    level = 4'b0000;
    repeat (XL + 1) step();
    chk("fall0_ignored", 32'(tick_a), 32'h0);
    level = 4'b0001;
    repeat (XL) step();
    clr = 4'b0001;
    step();
    clr = 4'b0000;
    chk("clr_ev_tick",  32'(tick_a),     32'h1);
    chk("clr_ev_pend",  32'(pend_a),     32'h1);
    chk("clr_ev_count", 32'(cnt_a[7:0]), 32'd1);
    clr = 4'b0001;
    step();
    clr = 4'b0000;
    chk("clr_tick",    32'(tick_a), 32'h0);
    chk("clr_pend",    32'(pend_a), 32'h0);
    chk("clr_count",   cnt_a,       32'd0);
    chk("clr_any_lag", 32'(any_a),  32'd1);
    step();
    chk("clr_any", 32'(any_a), 32'd0);

    // ch1 both edges, ch2 falling only, five toggles from level 0.
    mode   = 8'h6D;
    ticks1 = 0;
    ticks2 = 0;
    for (int i = 0; i < 5; i++) begin
      level[1] = ~level[1];
      level[2] = ~level[2];
      step();
      ticks1 += int'(tick_a[1]);
      ticks2 += int'(tick_a[2]);
    end
    for (int i = 0; i < XL; i++) begin
      step();
      ticks1 += int'(tick_a[1]);
      ticks2 += int'(tick_a[2]);
    end
    chk("both_ticks",   32'(ticks1),       32'd5);
    chk("fall_ticks",   32'(ticks2),       32'd2);
    chk("both_count",   32'(cnt_a[15:8]),  32'd5);
    chk("fall_count",   32'(cnt_a[23:16]), 32'd2);
    chk("toggle_pend",  32'(pend_a),       32'h6);
    chk("indep_ch0_3",  32'({cnt_a[31:24], cnt_a[7:0]}), 32'd0);
    chk("sat_b_ch1",    32'(cnt_b[3:2]),   32'd3);

    // Saturation on the 2-bit instance, ch3 rising events.
    for (int i = 0; i < 6; i++) begin
      level[3] = 1'b1;
      repeat (XL + 1) step();
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      chk("sat_count", 32'(cnt_b[7:6]), 32'(exp_cnt));
      chk("sat_pend",  32'(pend_b[3]),  32'd1);
      level[3] = 1'b0;
      step();
    end
    chk("nosat_count_a", 32'(cnt_a[31:24]), 32'd6);

    // Clearing ch1 leaves the other channels alone.
    repeat (XL) step();
    clr = 4'b0010;
    step();
    clr = 4'b0000;
    chk("indep_pend",  32'(pend_a),        32'hC);
    chk("indep_cnt1",  32'(cnt_a[15:8]),   32'd0);
    chk("indep_cnt2",  32'(cnt_a[23:16]),  32'd2);
    chk("indep_cnt3",  32'(cnt_a[31:24]),  32'd6);

    // Reset during an active tick cycle.
    level[0] = 1'b0;
    repeat (XL + 1) step();
    level[0] = 1'b1;
    repeat (XL + 1) step();
    chk("pre_rst_tick", 32'(tick_a), 32'h1);
    rst = 1'b1;
    step();
    chk("mid_rst_tick",  32'(tick_a), 32'h0);
    chk("mid_rst_pend",  32'(pend_a), 32'h0);
    chk("mid_rst_count", cnt_a,       32'd0);
    chk("mid_rst_any",   32'(any_a),  32'd0);
    chk("mid_rst_cnt_b", 32'(cnt_b),  32'd0);
    rst = 1'b0;
    quiet("post_rst_tick", 3 + XL);
    chk("post_rst_pend", 32'(pend_a), 32'h0);

    // Detection works again after the second reset.
    level[0] = 1'b0;
    repeat (XL + 1) step();
    level[0] = 1'b1;
    repeat (XL + 1) step();
    chk("rerise_tick",  32'(tick_a), 32'h1);
    chk("rerise_count", cnt_a,       32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
